// File: rtl/i2s_tx_asrc_pkg.sv
// i2s_tx_asrc_pkg
// Definitions shared by the I2S receive and transmit blocks: default
// frame geometry, word-select polarity, and the word-select pattern helper.
// No ports (package).
package i2s_tx_asrc_pkg;

    localparam int I2S_DATA_BITS_DEF = 16;
    localparam int SLOT_BITS_DEF     = 32;
    localparam int BCK_DIVIDER_DEF   = 4;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Philips I2S: WS switches one BCK ahead of each channel MSB, so the
    // right-channel WS window is [slot_bits-1, 2*slot_bits-2].
    function automatic logic ws_for_bit(input int unsigned k, input int unsigned slot_bits);
        if ((k >= (slot_bits - 32'd1)) && (k <= ((32'd2 * slot_bits) - 32'd2))) begin
            return WS_RIGHT;
        end else begin
            return WS_LEFT;
        end
    endfunction

endpackage

// File: rtl/i2s_tx_asrc_bck.sv
// i2s_bck_gen
// Divides the audio master clock down to the I2S bit clock and reports
// the AMCLK cycle on which BCK falls.
// Ports:
//   i_clk    audio master clock
//   i_rst_n  asynchronous active-low reset
//   o_bck    registered bit clock, i_clk / BCK_DIVIDER, 50% duty
//   o_fall   strobe, high in the cycle whose closing edge drops BCK
module i2s_bck_gen
    import i2s_tx_asrc_pkg::*;
#(
    parameter int BCK_DIVIDER = BCK_DIVIDER_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_bck,
    output logic o_fall
);

    localparam int DVW = $clog2(BCK_DIVIDER);
    localparam logic [DVW-1:0] DIV_RISE = DVW'(BCK_DIVIDER / 2 - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(BCK_DIVIDER - 1);

    logic [DVW-1:0] r_div_ctr;
    logic           r_bck;
    logic           w_rise;
    logic           w_fall;

    assign w_rise = (r_div_ctr == DIV_RISE);
    assign w_fall = (r_div_ctr == DIV_LAST);
    assign o_bck  = r_bck;
    assign o_fall = w_fall;

    // Free-running divider and the BCK register it drives.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_ctr <= {DVW{1'b0}};
            r_bck     <= 1'b0;
        end else begin
            if (w_fall) begin
                r_div_ctr <= {DVW{1'b0}};
            end else begin
                r_div_ctr <= r_div_ctr + DVW'(1);
            end
            if (w_rise) begin
                r_bck <= 1'b1;
            end else if (w_fall) begin
                r_bck <= 1'b0;
            end else begin
                r_bck <= r_bck;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_asrc.sv
// i2s_tx_asrc
// Free-running Philips I2S transmitter. Parallel L/R samples arriving at
// any rate land in a single-entry buffer; each frame start picks up the
// newest sample, or repeats the previous one when nothing new arrived.
// Ports:
//   AMCLK_i         audio master clock (only clock)
//   reset_n         asynchronous active-low reset
//   APDATA_LEFT_i   left sample, two's complement
//   APDATA_RIGHT_i  right sample, two's complement
//   APDATA_VALID_i  one-cycle strobe, L/R valid this cycle
//   I2S_BCK         bit clock
//   I2S_WS          word select (0 left, 1 right)
//   I2S_DATA        serial data, MSB first, changes with BCK fall
//   SAMPLE_REQ_o    pulse after every frame load
//   UNDERRUN_o      pulse after a frame load that repeated the old sample
//   OVERRUN_o       pulse when a pending sample was overwritten
module i2s_tx_asrc
    import i2s_tx_asrc_pkg::*;
#(
    parameter int I2S_DATA_BITS = I2S_DATA_BITS_DEF,
    parameter int SLOT_BITS     = SLOT_BITS_DEF,
    parameter int BCK_DIVIDER   = BCK_DIVIDER_DEF
) (
    input  logic                     AMCLK_i,
    input  logic                     reset_n,
    input  logic [I2S_DATA_BITS-1:0] APDATA_LEFT_i,
    input  logic [I2S_DATA_BITS-1:0] APDATA_RIGHT_i,
    input  logic                     APDATA_VALID_i,
    output logic                     I2S_BCK,
    output logic                     I2S_WS,
    output logic                     I2S_DATA,
    output logic                     SAMPLE_REQ_o,
    output logic                     UNDERRUN_o,
    output logic                     OVERRUN_o
);

    localparam int BW = $clog2(2 * SLOT_BITS);
    // One extra bit so slot-boundary constants never wrap when
    // I2S_DATA_BITS == SLOT_BITS.
    localparam int KW = BW + 1;
    localparam int IW = (I2S_DATA_BITS > 1) ? $clog2(I2S_DATA_BITS) : 1;

    localparam logic [BW-1:0] K_LAST  = BW'(2 * SLOT_BITS - 1);
    localparam logic [KW-1:0] K_DATA  = KW'(I2S_DATA_BITS);
    localparam logic [KW-1:0] K_SLOT  = KW'(SLOT_BITS);
    localparam logic [KW-1:0] K_R_END = KW'(SLOT_BITS + I2S_DATA_BITS);

    logic                     w_bck;
    logic                     w_fall;

    logic [BW-1:0]            r_bit_ctr;
    logic                     r_pending;
    logic [I2S_DATA_BITS-1:0] r_pend_l;
    logic [I2S_DATA_BITS-1:0] r_pend_r;
    logic [I2S_DATA_BITS-1:0] r_frame_l;
    logic [I2S_DATA_BITS-1:0] r_frame_r;
    logic                     r_ws;
    logic                     r_data;
    logic                     r_sample_req;
    logic                     r_underrun;
    logic                     r_overrun;

    logic                     w_load;
    logic [BW-1:0]            w_k;
    logic [KW-1:0]            w_kx;
    logic [I2S_DATA_BITS-1:0] w_src_l;
    logic [I2S_DATA_BITS-1:0] w_src_r;
    logic [IW-1:0]            w_lidx;
    logic [IW-1:0]            w_ridx;
    logic                     w_data_bit;
    logic                     w_ws_bit;

    i2s_bck_gen #(
        .BCK_DIVIDER (BCK_DIVIDER)
    ) u_bck_gen (
        .i_clk   (AMCLK_i),
        .i_rst_n (reset_n),
        .o_bck   (w_bck),
        .o_fall  (w_fall)
    );

    // Next bit position, frame-load decision and the WS/DATA values that
    // go out with the coming BCK fall. On a load edge the bit is taken
    // from the sample being loaded so the left MSB leaves on that edge.
    always_comb begin
        w_load = w_fall && (r_bit_ctr == K_LAST);
        if (r_bit_ctr == K_LAST) begin
            w_k = {BW{1'b0}};
        end else begin
            w_k = r_bit_ctr + BW'(1);
        end
        w_kx = {1'b0, w_k};

        if (w_load && APDATA_VALID_i) begin
            w_src_l = APDATA_LEFT_i;
            w_src_r = APDATA_RIGHT_i;
        end else if (w_load && r_pending) begin
            w_src_l = r_pend_l;
            w_src_r = r_pend_r;
        end else begin
            w_src_l = r_frame_l;
            w_src_r = r_frame_r;
        end

        w_lidx = IW'(K_DATA - KW'(1) - w_kx);
        w_ridx = IW'(K_R_END - KW'(1) - w_kx);
        if (w_kx < K_DATA) begin
            w_data_bit = w_src_l[w_lidx];
        end else if ((w_kx >= K_SLOT) && (w_kx < K_R_END)) begin
            w_data_bit = w_src_r[w_ridx];
        end else begin
            w_data_bit = 1'b0;
        end

        w_ws_bit = ws_for_bit(32'(w_k), SLOT_BITS);
    end

    // Bit counter, serial outputs, sample buffer and status pulses.
    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_ctr    <= K_LAST;
            r_pending    <= 1'b0;
            r_pend_l     <= {I2S_DATA_BITS{1'b0}};
            r_pend_r     <= {I2S_DATA_BITS{1'b0}};
            r_frame_l    <= {I2S_DATA_BITS{1'b0}};
            r_frame_r    <= {I2S_DATA_BITS{1'b0}};
            r_ws         <= WS_LEFT;
            r_data       <= 1'b0;
            r_sample_req <= 1'b0;
            r_underrun   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sample_req <= w_load;
            r_underrun   <= w_load && !APDATA_VALID_i && !r_pending;
            // A sample arriving on the load edge bypasses the buffer, so it
            // can never count as an overwrite.
            r_overrun    <= APDATA_VALID_i && r_pending && !w_load;

            if (w_fall) begin
                r_bit_ctr <= w_k;
                r_ws      <= w_ws_bit;
                r_data    <= w_data_bit;
            end else begin
                r_bit_ctr <= r_bit_ctr;
                r_ws      <= r_ws;
                r_data    <= r_data;
            end

            if (w_load) begin
                r_frame_l <= w_src_l;
                r_frame_r <= w_src_r;
            end else begin
                r_frame_l <= r_frame_l;
                r_frame_r <= r_frame_r;
            end

            if (w_load) begin
                r_pending <= 1'b0;
            end else if (APDATA_VALID_i) begin
                r_pending <= 1'b1;
            end else begin
                r_pending <= r_pending;
            end

            if (APDATA_VALID_i && !w_load) begin
                r_pend_l <= APDATA_LEFT_i;
                r_pend_r <= APDATA_RIGHT_i;
            end else begin
                r_pend_l <= r_pend_l;
                r_pend_r <= r_pend_r;
            end
        end
    end

    assign I2S_BCK      = w_bck;
    assign I2S_WS       = r_ws;
    assign I2S_DATA     = r_data;
    assign SAMPLE_REQ_o = r_sample_req;
    assign UNDERRUN_o   = r_underrun;
    assign OVERRUN_o    = r_overrun;

endmodule

// File: tb/tb_i2s_tx_asrc.sv
module tb_i2s_tx_asrc;

    localparam logic [63:0] WS_EXP = {31'b0, 32'hFFFF_FFFF, 1'b0};

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        valid    = 1'b0;
    logic [15:0] l_in     = 16'h0;
    logic [15:0] r_in     = 16'h0;
    logic        bck;
    logic        ws;
    logic        sdata;
    logic        sample_req;
    logic        underrun;
    logic        overrun;

    typedef struct {
        logic [63:0] bits;
        int          under;
        int          over;
    } exp_t;

    exp_t exp_q[$];
    int   errors      = 0;
    int   checks      = 0;
    int   cyc         = 0;
    int   frames_done = 0;

    i2s_tx_asrc #(
        .I2S_DATA_BITS (16),
        .SLOT_BITS     (32),
        .BCK_DIVIDER   (4)
    ) dut (
        .AMCLK_i        (clk),
        .reset_n        (rst_n),
        .APDATA_LEFT_i  (l_in),
        .APDATA_RIGHT_i (r_in),
        .APDATA_VALID_i (valid),
        .I2S_BCK        (bck),
        .I2S_WS         (ws),
        .I2S_DATA       (sdata),
        .SAMPLE_REQ_o   (sample_req),
        .UNDERRUN_o     (underrun),
        .OVERRUN_o      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r,
                              input int und, input int ovr);
        exp_t e;
        e.bits  = {l, 16'h0000, r, 16'h0000};
        e.under = und;
        e.over  = ovr;
        exp_q.push_back(e);
    endtask

    // Valid is driven so that AMCLK edge number c samples it.
    task automatic drive_valid_at(input int c, input logic [15:0] l, input logic [15:0] r);
        wait_cyc(c - 1);
        l_in  = l;
        r_in  = r;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    // Monitor: model receiver sampling DATA/WS on each BCK rise, assembling
    // 64-bit frames and checking them plus the pulse counts against the queue.
    initial begin : monitor
        int          cnt;
        bit          prev_bck;
        bit          active;
        int          nreq;
        int          nund;
        int          nov;
        logic [63:0] bits;
        logic [63:0] wsb;
        exp_t        e;
        cnt = 62; prev_bck = 1'b0; active = 1'b0;
        nreq = 0; nund = 0; nov = 0; bits = 64'h0; wsb = 64'h0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                cnt = 62; prev_bck = 1'b0; active = 1'b0;
                nreq = 0; nund = 0; nov = 0; bits = 64'h0; wsb = 64'h0;
            end else begin
                if (sample_req) nreq++;
                if (underrun)   nund++;
                if (overrun)    nov++;
                if (bck && !prev_bck) begin
                    cnt = (cnt == 63) ? 0 : cnt + 1;
                    if (cnt == 0) begin
                        active = 1'b1;
                    end
                    bits = {bits[62:0], sdata};
                    wsb  = {wsb[62:0], ws};
                    if (cnt == 63 && active) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected frame", 64'(frames_done), 64'(-1));
                        end else begin
                            e = exp_q.pop_front();
                            check("frame data", bits, e.bits);
                            check("ws pattern", wsb, WS_EXP);
                            check("sample_req count", 64'(nreq), 64'(1));
                            check("underrun count", 64'(nund), 64'(e.under));
                            check("overrun count", 64'(nov), 64'(e.over));
                        end
                        frames_done++;
                        nreq = 0; nund = 0; nov = 0;
                    end
                end
                prev_bck = bck;
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 64'({bck, ws, sdata, sample_req, underrun, overrun}), 64'(0));

        // Free run from reset: frame 0 repeats the zero sample.
        rst_n = 1'b1;
        cyc   = 0;
        push_frame(16'h0000, 16'h0000, 1, 0);
        tick();
        check("bck cycle1", 64'(bck), 64'(0));
        tick();
        check("bck cycle2 rise", 64'(bck), 64'(1));
        tick();
        check("bck cycle3", 64'(bck), 64'(1));
        tick();
        check("bck cycle4 fall", 64'(bck), 64'(0));
        check("first load pulses", 64'({sample_req, underrun}), 64'(2'b11));

        // Sample before frame 1; frame 1 window also sees the overrun below.
        drive_valid_at(100, 16'h8001, 16'h7FFE);
        push_frame(16'h8001, 16'h7FFE, 0, 1);

        // Two samples within frame 1: latest wins.
        drive_valid_at(310, 16'h1234, 16'hFEDC);
        drive_valid_at(330, 16'h5678, 16'h0F0F);
        check("overrun pulse", 64'(overrun), 64'(1));
        push_frame(16'h5678, 16'h0F0F, 0, 0);

        // One sample, then three starved frames repeating it.
        drive_valid_at(556, 16'hAAAA, 16'h5555);
        push_frame(16'hAAAA, 16'h5555, 0, 0);
        push_frame(16'hAAAA, 16'h5555, 1, 0);
        push_frame(16'hAAAA, 16'h5555, 1, 0);
        push_frame(16'hAAAA, 16'h5555, 1, 0);

        // Sample exactly on the frame-7 load edge (cycle 1796).
        drive_valid_at(1796, 16'h00FF, 16'hFF00);
        check("bypass pulses", 64'({sample_req, underrun, overrun}), 64'(3'b100));
        push_frame(16'h00FF, 16'hFF00, 0, 0);
        push_frame(16'h00FF, 16'hFF00, 1, 0);

        // Reset in the right slot of frame 9 (bit 40, BCK high).
        wait_cyc(2470);
        check("frames before reset", 64'(frames_done), 64'(9));
        check("right slot before reset", 64'({bck, ws}), 64'(2'b11));
        rst_n = 1'b0;
        #2;
        check("async reset outputs", 64'({bck, ws, sdata, sample_req, underrun, overrun}), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        l_in  = 16'hC3A5;
        r_in  = 16'h5A3C;
        valid = 1'b1;
        push_frame(16'hC3A5, 16'h5A3C, 0, 0);
        push_frame(16'hC3A5, 16'h5A3C, 1, 0);
        tick();
        valid = 1'b0;
        wait_cyc(4);
        check("msb after reset", 64'({sdata, ws}), 64'(2'b10));

        while (exp_q.size() != 0 && cyc < 800) tick();
        check("frames drained", 64'(exp_q.size()), 64'(0));
        check("frames total", 64'(frames_done), 64'(11));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx_asrc.md
Name: i2s_tx_asrc

Overview:
- Transmit counterpart of the YM I2S receive path.
- Accepts parallel signed L/R samples in the AMCLK_i domain at any rate.
- Holds the latest sample in a single-entry buffer and serializes it as a standard Philips I2S stream, with BCK and WS generated by dividing AMCLK_i.
- Feeds external DACs and HDMI/I2S transmitters from the audio processing chain; runs free regardless of input rate, repeating the last sample on underrun.

Parameters:
- I2S_DATA_BITS, 16: sample width; MSB-first, signed two's complement.
- SLOT_BITS, 32: BCK periods per channel slot; must be >= I2S_DATA_BITS.
- BCK_DIVIDER, 4: AMCLK_i cycles per BCK period; power of 2, >= 2.

Ports:
- AMCLK_i  in  1  audio master clock; only clock.
- reset_n  in  1  asynchronous, active-low reset.
- APDATA_LEFT_i  in  I2S_DATA_BITS  signed left sample.
- APDATA_RIGHT_i  in  I2S_DATA_BITS  signed right sample.
- APDATA_VALID_i  in  1  one-cycle strobe; L/R valid this cycle.
- I2S_BCK  out  1  bit clock, AMCLK_i/BCK_DIVIDER, 50% duty.
- I2S_WS  out  1  word select; 0 = left, 1 = right.
- I2S_DATA  out  1  serial data.
- SAMPLE_REQ_o  out  1  one-cycle pulse when a frame is loaded.
- UNDERRUN_o  out  1  one-cycle pulse: frame loaded with no new sample.
- OVERRUN_o  out  1  one-cycle pulse: pending sample overwritten.

Behaviour:
- Single clock domain; reset_n asynchronous, active-low.
- Reset values:
  - div_ctr = 0, bit_ctr = 2*SLOT_BITS-1, pending = 0.
  - Held L/R = 0, shift registers = 0.
  - I2S_BCK = I2S_WS = I2S_DATA = 0; all pulse outputs = 0.
- Divider: div_ctr increments every cycle and wraps at BCK_DIVIDER-1.
  - rise event: div_ctr == BCK_DIVIDER/2-1, so I2S_BCK <= 1.
  - fall event: div_ctr == BCK_DIVIDER-1, so I2S_BCK <= 0.
- On a fall event:
  - bit_ctr advances, wrapping 2*SLOT_BITS-1 -> 0.
  - I2S_WS and I2S_DATA update on the same AMCLK_i edge as the BCK fall, using the new bit_ctr value k.
- WS: I2S_WS = 1 for k in [SLOT_BITS-1, 2*SLOT_BITS-2], else 0. WS therefore leads each channel MSB by one BCK.
- DATA:
  - k < I2S_DATA_BITS: left bit [I2S_DATA_BITS-1-k].
  - SLOT_BITS <= k < SLOT_BITS+I2S_DATA_BITS: right bit [I2S_DATA_BITS-1-(k-SLOT_BITS)].
  - Otherwise 0 (padding).
- Input buffer:
  - APDATA_VALID_i captures L/R into the pending register and sets pending.
  - If pending is already set, the new sample overwrites it (latest wins) and OVERRUN_o pulses.
- Frame load: occurs on the fall event where bit_ctr wraps to 0.
  - pending set: load pending L/R into the shift registers, clear pending, pulse SAMPLE_REQ_o.
  - pending clear: reload the previous held sample and pulse both SAMPLE_REQ_o and UNDERRUN_o.
  - Pulses are asserted the cycle after the load edge.
- APDATA_VALID_i in the same cycle as the load (bypass): the input sample is loaded directly, pending stays 0, and there is no overrun or underrun.
- Latency: a sample accepted before the load edge has its left MSB on I2S_DATA at that edge. Worst case is one frame (2*SLOT_BITS*BCK_DIVIDER cycles) plus one cycle.
- Frame cadence is free-running and independent of the input; the input never stalls the output.
- Reset mid-frame: all outputs return to reset values immediately (async). After release, the first fall event (AMCLK_i cycle BCK_DIVIDER) starts a fresh frame at bit 0 with left data.

Decomposition:
- Shared package/include:
  - I2S_DATA_BITS, SLOT_BITS and BCK_DIVIDER defaults.
  - WS polarity constants (WS_LEFT = 0, WS_RIGHT = 1).
  - Common to the rx and tx blocks.
- Sub-module i2s_bck_gen: div_ctr, I2S_BCK register, and rise/fall event strobes.
- Top level: bit_ctr, WS/DATA mux, pending buffer, load logic.

Test Plan (I2S_DATA_BITS = 16, SLOT_BITS = 32, BCK_DIVIDER = 4; frame = 256 cycles):
- Reset release, no input:
  - I2S_BCK rises at cycle 2 and falls at cycle 4.
  - WS = 0 for bits 0-30, 1 for bits 31-62, 0 at bit 63.
  - DATA is constantly 0.
  - UNDERRUN_o and SAMPLE_REQ_o pulse every 256 cycles.
- VALID with L = 16'h8001, R = 16'h7FFE before a frame start:
  - Left slot serializes 1000000000000001 followed by 16 zeros.
  - Right slot serializes 0111111111111110.
  - Checked by a model receiver sampling on BCK rise.
- Two VALIDs within one frame (L = 16'h1234, then 16'h5678):
  - OVERRUN_o pulses once.
  - Next frame carries 16'h5678.
- No VALID for 3 frames after L/R = 16'hAAAA/16'h5555:
  - All 3 frames repeat AAAA/5555.
  - 3 UNDERRUN_o pulses.
- VALID in exactly the load cycle with L = 16'h00FF:
  - That frame carries 00FF.
  - No UNDERRUN_o or OVERRUN_o; pending = 0 afterwards.
- reset_n asserted mid right slot:
  - BCK, WS and DATA are 0 asynchronously.
  - After release, left MSB of the next loaded sample appears at cycle 4 with WS = 0.
